// File: rtl/cdi_bus_pkg.sv
// Shared types, CD-i memory map constants and the region decoder used by the bus controller.
package cdi_bus_pkg;

    typedef enum logic [3:0] {
        REG_NONE     = 4'd0,
        REG_RAM_A    = 4'd1,
        REG_RAM_B    = 4'd2,
        REG_CDIC     = 4'd3,
        REG_SLAVE    = 4'd4,
        REG_NVRAM    = 4'd5,
        REG_ROM      = 4'd6,
        REG_VSC      = 4'd7,
        REG_UNMAPPED = 4'd8
    } region_t;

    typedef enum logic [2:0] {StIdle, StWait, StAck, StErr, StRecover} state_t;

    localparam logic [23:0] RAM_A_LIMIT = 24'h07FFFF;
    localparam logic [23:0] RAM_B_BASE  = 24'h200000;
    localparam logic [23:0] RAM_B_LIMIT = 24'h27FFFF;
    localparam logic [23:0] CDIC_BASE   = 24'h300000;
    localparam logic [23:0] CDIC_LIMIT  = 24'h303FFF;
    localparam logic [23:0] SLAVE_BASE  = 24'h310000;
    localparam logic [23:0] SLAVE_LIMIT = 24'h31FFFF;
    localparam logic [23:0] NVRAM_BASE  = 24'h320000;
    localparam logic [23:0] NVRAM_LIMIT = 24'h321FFF;
    localparam logic [23:0] ROM_BASE    = 24'h400000;
    localparam logic [23:0] ROM_LIMIT   = 24'h47FFFF;
    localparam logic [23:0] VSC_BASE    = 24'h4FFFE0;
    localparam logic [23:0] VSC_LIMIT   = 24'h4FFFFF;

    function automatic logic in_range(input logic [23:0] b, input logic [23:0] lo,
                                      input logic [23:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

    // overlay must already be qualified with "this is a read" by the caller
    function automatic region_t decode_region(input logic [23:1] addr, input logic overlay);
        logic [23:0] b;
        b = {addr, 1'b0};
        if (b <= RAM_A_LIMIT)                       return overlay ? REG_ROM : REG_RAM_A;
        if (in_range(b, RAM_B_BASE, RAM_B_LIMIT))   return REG_RAM_B;
        if (in_range(b, CDIC_BASE, CDIC_LIMIT))     return REG_CDIC;
        if (in_range(b, SLAVE_BASE, SLAVE_LIMIT))   return REG_SLAVE;
        if (in_range(b, NVRAM_BASE, NVRAM_LIMIT))   return REG_NVRAM;
        if (in_range(b, ROM_BASE, ROM_LIMIT))       return REG_ROM;
        if (in_range(b, VSC_BASE, VSC_LIMIT))       return REG_VSC;
        return REG_UNMAPPED;
    endfunction

    function automatic logic is_ready_type(input region_t r);
        return (r == REG_CDIC) || (r == REG_SLAVE) || (r == REG_VSC);
    endfunction

    function automatic logic in_real_rom(input logic [23:1] addr);
        return in_range({addr, 1'b0}, ROM_BASE, ROM_LIMIT);
    endfunction

endpackage

// File: rtl/cpu_bus_ctrl.sv
// SCC68070 external bus controller: region decode, wait states, ready handshake,
// boot ROM overlay and bus timeout.
module cpu_bus_ctrl
    import cdi_bus_pkg::*;
#(
    parameter int unsigned RAM_WAIT   = 1,
    parameter int unsigned ROM_WAIT   = 2,
    parameter int unsigned NVRAM_WAIT = 3,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as,
    input  logic        uds,
    input  logic        lds,
    input  logic        write_strobe,
    input  logic [23:1] addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        bus_ack,
    output logic        bus_err,
    output logic [2:0]  dev_sel,
    output logic        dev_req,
    output logic        dev_we,
    output logic        dev_uds,
    output logic        dev_lds,
    output logic [23:1] dev_addr,
    output logic [15:0] dev_wdata,
    input  logic [15:0] dev_rdata,
    input  logic        dev_ack
);

    function automatic int unsigned wait_of(input region_t r);
        case (r)
            REG_RAM_A, REG_RAM_B: return RAM_WAIT;
            REG_NVRAM:            return NVRAM_WAIT;
            REG_ROM:              return ROM_WAIT;
            default:              return 0;
        endcase
    endfunction

    state_t      state_q;
    region_t     region_q;
    logic        overlay_q;
    logic [9:0]  cnt_q;

    region_t     region_in;
    logic        start, complete, timeout, err_now, comp_we, comp_rom;

    always_comb begin
        region_in = decode_region(addr, overlay_q & ~write_strobe);
        start     = (state_q == StIdle) && as && (uds || lds);
        timeout   = (state_q == StWait) && is_ready_type(region_q) && !dev_ack &&
                    (cnt_q == 10'(TIMEOUT));
        complete  = 1'b0;
        if (start && region_in != REG_UNMAPPED && !is_ready_type(region_in) &&
            wait_of(region_in) == 0) begin
            complete = 1'b1;
        end else if (state_q == StWait) begin
            complete = is_ready_type(region_q) ? dev_ack :
                       (cnt_q == 10'(wait_of(region_q) - 1));
        end
        err_now   = timeout || (start && region_in == REG_UNMAPPED);
        // zero-wait accesses complete on the entry cycle, before the registers hold them
        comp_we   = start ? write_strobe : dev_we;
        comp_rom  = start ? in_real_rom(addr) : in_real_rom(dev_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            region_q  <= REG_NONE;
            overlay_q <= 1'b1;
            cnt_q     <= '0;
            cpu_rdata <= '0;
            bus_ack   <= 1'b0;
            bus_err   <= 1'b0;
            dev_sel   <= '0;
            dev_req   <= 1'b0;
            dev_we    <= 1'b0;
            dev_uds   <= 1'b0;
            dev_lds   <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
        end else begin
            bus_ack <= complete || err_now;
            bus_err <= err_now;
            if (complete) begin
                if (!comp_we) cpu_rdata <= dev_rdata;
                if (comp_rom) overlay_q <= 1'b0;
            end
            if (complete || err_now) begin
                dev_req <= 1'b0;
                dev_sel <= '0;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        dev_addr  <= addr;
                        dev_we    <= write_strobe;
                        dev_uds   <= uds;
                        dev_lds   <= lds;
                        dev_wdata <= cpu_wdata;
                        region_q  <= region_in;
                        cnt_q     <= '0;
                        if (region_in == REG_UNMAPPED) begin
                            state_q <= StErr;
                        end else if (complete) begin
                            state_q <= StAck;
                        end else begin
                            state_q <= StWait;
                            dev_req <= 1'b1;
                            dev_sel <= region_in[2:0];
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 10'd1;
                    if (complete)     state_q <= StAck;
                    else if (timeout) state_q <= StErr;
                end
                StAck, StErr: state_q <= StRecover;
                StRecover:    state_q <= StIdle;
                default:      state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl: directed memory-map scenarios plus randomized
// accesses against a transaction-level model of latency, error, read data and overlay.
module tb_cpu_bus_ctrl;

    localparam int TMO = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        as = 1'b0, uds = 1'b0, lds = 1'b0, write_strobe = 1'b0;
    logic [23:1] addr = '0;
    logic [15:0] cpu_wdata = '0, dev_rdata = '0;
    logic        dev_ack = 1'b0;
    logic [15:0] cpu_rdata;
    logic        bus_ack, bus_err, dev_req, dev_we, dev_uds, dev_lds;
    logic [2:0]  dev_sel;
    logic [23:1] dev_addr;
    logic [15:0] dev_wdata;

    int          n_checks = 0;
    int          n_fail = 0;
    logic        ovl_m;
    logic [15:0] rdata_m;

    cpu_bus_ctrl dut (
        .clk(clk), .reset(reset), .as(as), .uds(uds), .lds(lds),
        .write_strobe(write_strobe), .addr(addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .dev_sel(dev_sel), .dev_req(dev_req), .dev_we(dev_we), .dev_uds(dev_uds),
        .dev_lds(dev_lds), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_rdata(dev_rdata), .dev_ack(dev_ack)
    );

    always #5 clk = ~clk;

    // Region codes: 1 RAM_A, 2 RAM_B, 3 CDIC, 4 SLAVE, 5 NVRAM, 6 ROM, 7 VSC, 8 unmapped
    function automatic int region_of(input logic [23:0] b, input bit ovl);
        if (b < 24'h080000)                      return ovl ? 6 : 1;
        if (b >= 24'h200000 && b < 24'h280000)   return 2;
        if (b >= 24'h300000 && b < 24'h304000)   return 3;
        if (b >= 24'h310000 && b < 24'h320000)   return 4;
        if (b >= 24'h320000 && b < 24'h322000)   return 5;
        if (b >= 24'h400000 && b < 24'h480000)   return 6;
        if (b >= 24'h4FFFE0 && b < 24'h500000)   return 7;
        return 8;
    endfunction

    function automatic int wait_of(input int r);
        if (r == 1 || r == 2) return 1;
        if (r == 5)           return 3;
        if (r == 6)           return 2;
        return 0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"}, bus_ack, 0);
        check_eq({tag, "_err"}, bus_err, 0);
        check_eq({tag, "_req"}, dev_req, 0);
        check_eq({tag, "_sel"}, dev_sel, 0);
        check_eq({tag, "_rdata"}, cpu_rdata, 0);
        check_eq({tag, "_strobes"}, {dev_we, dev_uds, dev_lds}, 0);
        check_eq({tag, "_addr"}, dev_addr, 0);
        check_eq({tag, "_wdata"}, dev_wdata, 0);
    endtask

    // Called at a negedge with the DUT idle; dly = cycles after dev_req rises before
    // dev_ack is shown (negative = never).
    task automatic access(input logic [23:0] b, input logic we, input logic u, input logic l,
                          input logic [15:0] wd, input logic [15:0] rd, input int dly);
        int r, exp_lat, lat;
        bit exp_err, ready, seen;
        r     = region_of(b, ovl_m && !we);
        ready = (r == 3 || r == 4 || r == 7);
        if (r == 8) begin
            exp_lat = 1; exp_err = 1;
        end else if (ready) begin
            if (dly >= 0 && dly <= TMO) begin exp_lat = dly + 2; exp_err = 0; end
            else begin exp_lat = TMO + 2; exp_err = 1; end
        end else begin
            exp_lat = 1 + wait_of(r); exp_err = 0;
        end
        as = 1'b1; uds = u; lds = l; write_strobe = we; addr = b[23:1];
        cpu_wdata = wd; dev_rdata = rd; dev_ack = 1'b0;
        seen = 0; lat = 0;
        for (int k = 1; k <= 1200 && !seen; k++) begin
            @(negedge clk);
            if (bus_ack) begin
                seen = 1; lat = k;
            end else begin
                if (k == 1) begin
                    check_eq("dev_req", dev_req, 1);
                    check_eq("dev_sel", dev_sel, r);
                    check_eq("dev_addr", dev_addr, b[23:1]);
                    check_eq("dev_strobes", {dev_we, dev_uds, dev_lds}, {we, u, l});
                    if (we) check_eq("dev_wdata", dev_wdata, wd);
                end
                dev_ack = ready && (k - 1 == dly);
            end
        end
        dev_ack = 1'b0; as = 1'b0; uds = 1'b0; lds = 1'b0;
        check_eq("ack_seen", seen, 1);
        check_eq("latency", lat, exp_lat);
        check_eq("bus_err", bus_err, exp_err);
        check_eq("dev_req_at_ack", dev_req, 0);
        if (!exp_err) begin
            if (!we) rdata_m = rd;
            if (b >= 24'h400000 && b < 24'h480000) ovl_m = 1'b0;
        end
        check_eq("cpu_rdata", cpu_rdata, rdata_m);
        @(negedge clk);
        check_eq("ack_pulse", bus_ack, 0);
        @(negedge clk);
    endtask

    initial begin
        int unsigned bases [9] = '{24'h000000, 24'h200000, 24'h300000, 24'h310000, 24'h320000,
                                   24'h400000, 24'h4FFFE0, 24'h600000, 24'h304000};
        int unsigned sizes [9] = '{24'h080000, 24'h080000, 24'h004000, 24'h010000, 24'h002000,
                                   24'h080000, 24'h000020, 24'h100000, 24'h00C000};
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0; ovl_m = 1'b1; rdata_m = '0;
        @(negedge clk);

        access(24'h000000, 0, 1, 1, 16'h0000, 16'h4AFC, -1);
        access(24'h400004, 0, 1, 1, 16'h0000, 16'h1111, -1);
        access(24'h000000, 0, 1, 1, 16'h0000, 16'h2222, -1);
        access(24'h200010, 1, 1, 1, 16'h1234, 16'hDEAD, -1);
        access(24'h320100, 0, 0, 1, 16'h0000, 16'h3333, -1);
        access(24'h4FFFE0, 0, 1, 1, 16'h0000, 16'h5A5A, 7);
        access(24'h300000, 0, 1, 1, 16'h0000, 16'h6666, -1);
        access(24'h300002, 0, 1, 1, 16'h0000, 16'h7777, TMO);
        access(24'h310000, 0, 1, 0, 16'h0000, 16'h8888, TMO + 1);
        access(24'h600000, 0, 1, 1, 16'h0000, 16'h9999, -1);

        // Reset while a ROM read is waiting
        as = 1'b1; uds = 1'b1; lds = 1'b1; write_strobe = 1'b0; addr = 23'h200008;
        @(negedge clk);
        check_eq("mid_req", dev_req, 1);
        reset = 1'b1; as = 1'b0; uds = 1'b0; lds = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset = 1'b0; ovl_m = 1'b1; rdata_m = '0;
        @(negedge clk);
        access(24'h000000, 0, 1, 1, 16'h0000, 16'hABCD, -1);
        access(24'h000100, 1, 0, 1, 16'h4321, 16'h0F0F, -1);

        for (int i = 0; i < 80; i++) begin
            int unsigned idx, off;
            logic [23:0] b;
            logic [1:0]  ul;
            idx = $urandom_range(0, 8);
            off = $urandom % sizes[idx];
            b = 24'(bases[idx] + off);
            b[0] = 1'b0;
            ul = 2'($urandom_range(1, 3));
            access(b, 1'($urandom), ul[1], ul[0], 16'($urandom), 16'($urandom),
                   $urandom_range(0, 10));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
